// File: rtl/jam_cost_table.sv
// 8x8 cost table for the job-assignment engine: serial row-major load after reset,
// then zero-latency lookup of table[W][J]; also a load checksum and a lookup counter.
//   state   | meaning
//   S_IDLE  | no valid table; waiting for load_start
//   S_LOAD  | accepting entries at ptr_q (load_ready=1)
//   S_READY | table valid; Cost answers lookups, lookup_cnt runs
module jam_cost_table #(
  parameter int COST_W = 7,
  parameter int N      = 8,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [COST_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
  output logic              table_ready,
  input  logic [2:0]        W,
  input  logic [2:0]        J,
  output logic [COST_W-1:0] Cost,
  output logic [12:0]       checksum,
  output logic [CNT_W-1:0]  lookup_cnt
);

  localparam int SUM_W = 13;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READY} state_e;

  state_e            state_q;
  logic [5:0]        ptr_q;
  logic [SUM_W-1:0]  sum_q;
  logic [SUM_W-1:0]  sum_d;
  logic [SUM_W-1:0]  checksum_q;
  logic [CNT_W-1:0]  lookup_cnt_q;
  logic              load_ready_q;
  logic              load_done_q;
  logic              table_ready_q;
  logic [COST_W-1:0] cost_mem_q [N*N];

  assign sum_d = sum_q + {{(SUM_W-COST_W){1'b0}}, load_data};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      sum_q         <= '0;
      checksum_q    <= '0;
      lookup_cnt_q  <= '0;
      load_ready_q  <= 1'b0;
      load_done_q   <= 1'b0;
      table_ready_q <= 1'b0;
      for (int i = 0; i < N*N; i++) cost_mem_q[i] <= '0;
    end else begin
      load_done_q <= 1'b0;
      if (state_q == S_READY && lookup_cnt_q != {CNT_W{1'b1}})
        lookup_cnt_q <= lookup_cnt_q + 1'b1;
      // A start pulse always wins, including over a beat offered in the same cycle.
      if (load_start) begin
        state_q       <= S_LOAD;
        load_ready_q  <= 1'b1;
        table_ready_q <= 1'b0;
        ptr_q         <= '0;
        sum_q         <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            ptr_q <= '0;
            sum_q <= '0;
          end
          S_LOAD: begin
            if (load_valid) begin
              cost_mem_q[ptr_q] <= load_data;
              ptr_q             <= ptr_q + 6'd1;
              sum_q             <= sum_d;
              if (ptr_q == 6'd63) begin
                state_q       <= S_READY;
                load_ready_q  <= 1'b0;
                table_ready_q <= 1'b1;
                load_done_q   <= 1'b1;
                checksum_q    <= sum_d;
                lookup_cnt_q  <= '0;
              end
            end
          end
          S_READY: ;
          default: begin
            state_q       <= S_IDLE;
            load_ready_q  <= 1'b0;
            table_ready_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // W and J arrive registered, so the lookup is a single mux level off the table.
  assign Cost        = table_ready_q ? cost_mem_q[{W, J}] : '0;
  assign load_ready  = load_ready_q;
  assign load_done   = load_done_q;
  assign table_ready = table_ready_q;
  assign checksum    = checksum_q;
  assign lookup_cnt  = lookup_cnt_q;

endmodule

// File: tb/tb_jam_cost_table.sv
// Scoreboard bench for jam_cost_table: stimulus queues expectations for the
// current cycle, a negedge monitor pops and compares them.
module tb_jam_cost_table;
  localparam int COST_W = 7;
  localparam int CNT_W  = 16;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              load_start = 1'b0;
  logic              load_valid = 1'b0;
  logic [COST_W-1:0] load_data = '0;
  logic              load_ready;
  logic              load_done;
  logic              table_ready;
  logic [2:0]        W = 3'd3;
  logic [2:0]        J = 3'd5;
  logic [COST_W-1:0] Cost;
  logic [12:0]       checksum;
  logic [CNT_W-1:0]  lookup_cnt;

  jam_cost_table #(.COST_W(COST_W), .N(8), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .load_done(load_done), .table_ready(table_ready),
    .W(W), .J(J), .Cost(Cost), .checksum(checksum), .lookup_cnt(lookup_cnt)
  );

  always #5 CLK = ~CLK;

  typedef enum int {K_COST, K_SUM, K_CNT, K_TRDY, K_LRDY, K_DONE} kind_e;
  typedef struct {
    string name;
    kind_e kind;
    int    exp;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [COST_W-1:0] vals [64];

  task automatic chk(input string name, input kind_e k, input int v);
    exp_t e;
    e.name = name;
    e.kind = k;
    e.exp  = v;
    exp_q.push_back(e);
  endtask

  function automatic int dut_val(input kind_e k);
    case (k)
      K_COST:  return int'(Cost);
      K_SUM:   return int'(checksum);
      K_CNT:   return int'(lookup_cnt);
      K_TRDY:  return int'(table_ready);
      K_LRDY:  return int'(load_ready);
      default: return int'(load_done);
    endcase
  endfunction

  always @(negedge CLK) begin : monitor
    exp_t e;
    int   got;
    int   want;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = dut_val(e.kind);
      n_cmp++;
      if (got != e.exp) begin
        n_bad++;
        $display("FAIL %s: got %0d expected %0d (t=%0t)", e.name, got, e.exp, $time);
      end
    end
    if (load_done === 1'b1) begin
      n_cmp++;
      if (done_q.size() == 0) begin
        n_bad++;
        $display("FAIL done_unexpected: got load_done=1 expected no completion (t=%0t)", $time);
      end else begin
        want = done_q.pop_front();
        if (int'(checksum) != want) begin
          n_bad++;
          $display("FAIL done_checksum: got %0d expected %0d (t=%0t)", checksum, want, $time);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_pulse();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  function automatic int model_sum();
    int s = 0;
    for (int i = 0; i < 64; i++) s += int'(vals[i]);
    return s;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_trdy"}, K_TRDY, 0);
    chk({tag, "_lrdy"}, K_LRDY, 0);
    chk({tag, "_done"}, K_DONE, 0);
    chk({tag, "_sum"},  K_SUM,  0);
    chk({tag, "_cnt"},  K_CNT,  0);
    chk({tag, "_cost"}, K_COST, 0);
  endtask

  // Streams vals[0..63]; returns just after the completing edge (first READY cycle).
  task automatic load_all(input bit gaps, input int prev_sum);
    done_q.push_back(model_sum());
    for (int i = 0; i < 64; i++) begin
      load_valid = 1'b1;
      load_data  = vals[i];
      if (i == 10) begin
        chk("cost_during_load", K_COST, 0);
        chk("lrdy_during_load", K_LRDY, 1);
        chk("sum_held_during_load", K_SUM, prev_sum);
      end
      step();
      load_valid = 1'b0;
      if (gaps && i != 63) begin
        load_data = 7'h55;
        if (i == 62) chk("trdy_before_last_beat", K_TRDY, 0);
        step();
      end
    end
    chk("done_pulse", K_DONE, 1);
    chk("trdy_rise", K_TRDY, 1);
    chk("cnt_restart", K_CNT, 0);
    chk("checksum", K_SUM, model_sum());
  endtask

  task automatic sweep(input int v, input string tag);
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++) begin
        W = w[2:0];
        J = j[2:0];
        chk(tag, K_COST, v);
        step();
      end
  endtask

  initial begin
    // Reset state
    chk_reset("reset");
    #12 RST_N = 1'b1;
    step();

    // load_valid in IDLE is ignored
    load_valid = 1'b1;
    load_data  = 7'd50;
    chk("idle_lrdy", K_LRDY, 0);
    chk("idle_trdy", K_TRDY, 0);
    step();
    load_valid = 1'b0;

    // Test 1: ramp 0..63
    for (int i = 0; i < 64; i++) vals[i] = i[6:0];
    W = 3'd7; J = 3'd7;
    start_pulse();
    chk("load_entry_lrdy", K_LRDY, 1);
    load_all(1'b0, 0);
    W = 3'd3; J = 3'd5;
    chk("ramp_cost_3_5", K_COST, 29);
    chk("ramp_checksum_2016", K_SUM, 2016);

    // Test 5: 10 READY cycles then restart
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 1) chk("done_one_cycle", K_DONE, 0);
      if (k == 5) chk("cnt_5", K_CNT, 5);
    end
    chk("cnt_at_start", K_CNT, 10);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("restart_trdy", K_TRDY, 0);
    chk("restart_lrdy", K_LRDY, 1);
    chk("restart_cost", K_COST, 0);
    chk("restart_sum_held", K_SUM, 2016);

    // Test 2: all 127 with gaps
    for (int i = 0; i < 64; i++) vals[i] = 7'd127;
    load_all(1'b1, 2016);
    chk("max_checksum_8128", K_SUM, 8128);
    sweep(127, "cost_127");
    chk("cnt_after_sweep", K_CNT, 64);

    // Test 3: restart mid-load with a colliding beat
    start_pulse();
    for (int i = 0; i < 20; i++) begin
      load_valid = 1'b1;
      load_data  = 7'd5;
      step();
    end
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data  = 7'd99;
    step();
    load_start = 1'b0;
    load_valid = 1'b0;
    for (int i = 0; i < 64; i++) vals[i] = 7'd1;
    load_all(1'b0, 8128);
    chk("ones_checksum_64", K_SUM, 64);
    sweep(1, "cost_1");

    // Test 4: Cost at (7,7) before and at completion
    for (int i = 0; i < 64; i++) vals[i] = 7'((i * 5) % 97);
    vals[63] = 7'd42;
    W = 3'd7; J = 3'd7;
    start_pulse();
    chk("cost_7_7_loading", K_COST, 0);
    load_all(1'b0, 64);
    chk("cost_7_7_ready", K_COST, 42);

    // Test 6: async reset during beat 30
    for (int i = 0; i < 64; i++) vals[i] = 7'((i * 7 + 3) % 128);
    start_pulse();
    for (int i = 0; i <= 30; i++) begin
      load_valid = 1'b1;
      load_data  = vals[i];
      if (i < 30) step();
    end
    #1 RST_N = 1'b0;
    chk_reset("async_rst");
    step();
    load_valid = 1'b0;
    step();
    #2 RST_N = 1'b1;
    step();
    chk("post_rst_trdy", K_TRDY, 0);
    start_pulse();
    load_all(1'b0, 0);
    W = 3'd0; J = 3'd0;
    chk("post_rst_cost_0_0", K_COST, 3);

    step();
    step();
    n_cmp++;
    if (done_q.size() != 0) begin
      n_bad++;
      $display("FAIL done_missing: got %0d pending completions expected 0", done_q.size());
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
